// File: rtl/output_drain_controller.sv
// Output-BRAM owner between layers: zero-sweeps the BRAM on request and streams a finished
// layer's results out over AXI-Stream, holding off the compute path while it owns the port.
module output_drain_controller #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int LEN0   = 1024,
    parameter int LEN1   = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_output_bram,
    input  logic              all_batches_complete,
    input  logic [1:0]        current_layer_id,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              hold_compute,
    output logic              clear_done,
    output logic              drain_done
);

    // state | meaning
    // IDLE  | port released (unless a request is pending)
    // CLEAR | writing zeros to addr 0..DEPTH-1, one per cycle
    // DRAIN | issuing reads 0..len-1 into the skid buffer
    // FLUSH | all reads issued, waiting for the tlast handshake
    typedef enum logic [1:0] {IDLE, CLEAR, DRAIN, FLUSH} state_t;

    localparam int CW = ADDR_W + 1;

    state_t            state;
    state_t            state_nxt;
    logic              clr_prev;
    logic              drn_prev;
    logic              clear_pend;
    logic              drain_pend;
    logic [CW-1:0]     wr_cnt;
    logic [CW-1:0]     rd_cnt;
    logic [CW-1:0]     hs_cnt;
    logic [CW-1:0]     len;
    logic              rd_inflight;
    logic [DATA_W-1:0] skid [2];
    logic              skid_wp;
    logic              skid_rp;
    logic [1:0]        skid_cnt;

    logic              clr_rise;
    logic              drn_rise;
    logic              start_drain;
    logic              start_clear;
    logic              pop;
    logic              rd_issue;
    logic              last_read;
    logic              last_write;
    logic              last_hs;
    logic [2:0]        occ;

    assign clr_rise    = clear_output_bram & ~clr_prev;
    assign drn_rise    = all_batches_complete & ~drn_prev;
    assign start_drain = (state == IDLE) & drain_pend;
    assign start_clear = (state == IDLE) & ~drain_pend & clear_pend;
    assign pop         = m_axis_tvalid & m_axis_tready;
    assign last_read   = (rd_cnt == len - CW'(1));
    assign last_write  = (wr_cnt == CW'(DEPTH - 1));
    assign last_hs     = pop & m_axis_tlast;

    // A word leaving the buffer this cycle frees its slot, which keeps full-ready at 1 word/cycle.
    assign occ      = {1'b0, skid_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign rd_issue = (state == DRAIN) && (occ < 3'd2);

    assign m_axis_tvalid = (skid_cnt != 2'd0);
    assign m_axis_tdata  = skid[skid_rp];
    assign m_axis_tlast  = m_axis_tvalid & (hs_cnt == len - CW'(1));
    assign hold_compute  = (state != IDLE) | clear_pend | drain_pend;
    assign bram_wdata    = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (drain_pend)      state_nxt = DRAIN;
                else if (clear_pend) state_nxt = CLEAR;
            end
            CLEAR:   if (last_write)            state_nxt = IDLE;
            DRAIN:   if (rd_issue && last_read) state_nxt = FLUSH;
            FLUSH:   if (last_hs)               state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        case (state)
            CLEAR: begin
                bram_en   = 1'b1;
                bram_we   = 1'b1;
                bram_addr = wr_cnt[ADDR_W-1:0];
            end
            DRAIN: begin
                if (rd_issue) begin
                    bram_en   = 1'b1;
                    bram_addr = rd_cnt[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_prev    <= 1'b0;
            drn_prev    <= 1'b0;
            clear_pend  <= 1'b0;
            drain_pend  <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            hs_cnt      <= '0;
            len         <= '0;
            rd_inflight <= 1'b0;
            skid[0]     <= '0;
            skid[1]     <= '0;
            skid_wp     <= 1'b0;
            skid_rp     <= 1'b0;
            skid_cnt    <= 2'd0;
            clear_done  <= 1'b0;
            drain_done  <= 1'b0;
        end else begin
            clr_prev   <= clear_output_bram;
            drn_prev   <= all_batches_complete;
            drain_pend <= drn_rise | (drain_pend & ~start_drain);
            clear_pend <= clr_rise | (clear_pend & ~start_clear);

            if (start_drain) begin
                len    <= (current_layer_id == 2'd1) ? CW'(LEN1) : CW'(LEN0);
                rd_cnt <= '0;
                hs_cnt <= '0;
            end else begin
                if (rd_issue) rd_cnt <= rd_cnt + CW'(1);
                if (pop)      hs_cnt <= hs_cnt + CW'(1);
            end

            if (start_clear)         wr_cnt <= '0;
            else if (state == CLEAR) wr_cnt <= wr_cnt + CW'(1);

            rd_inflight <= rd_issue;
            if (rd_inflight) begin
                skid[skid_wp] <= bram_rdata;
                skid_wp       <= ~skid_wp;
            end
            if (pop) skid_rp <= ~skid_rp;
            skid_cnt <= skid_cnt + {1'b0, rd_inflight} - {1'b0, pop};

            clear_done <= (state == CLEAR) & last_write;
            drain_done <= (state == FLUSH) & last_hs;
        end
    end

endmodule

// File: tb/tb_output_drain_controller.sv
// Bench for output_drain_controller: BRAM model, transaction-level reference checked every
// cycle, and directed scenarios with hand-computed timing and data.
module tb_output_drain_controller;
    localparam int AW = 10, DW = 16, DEPTH = 1024, LEN0 = 1024, LEN1 = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_output_bram = 1'b0;
    logic          all_batches_complete = 1'b0;
    logic [1:0]    current_layer_id = 2'd0;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          hold_compute, clear_done, drain_done;

    always #5 clk = ~clk;

    output_drain_controller #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .LEN0(LEN0), .LEN1(LEN1)) dut (
        .clk(clk), .rst(rst),
        .clear_output_bram(clear_output_bram),
        .all_batches_complete(all_batches_complete),
        .current_layer_id(current_layer_id),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .hold_compute(hold_compute), .clear_done(clear_done), .drain_done(drain_done)
    );

    // BRAM with 1-cycle read latency; load_req fills it with i ^ load_key.
    logic [DW-1:0] mem [DEPTH];
    logic          load_req = 1'b0;
    logic [DW-1:0] load_key = '0;
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i) ^ load_key;
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         bram_rdata <= mem[bram_addr];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pending requests, the current operation, and the stream it must produce.
    int            m_mode;
    bit            m_prev_c, m_prev_d, m_cp, m_dp, m_cd, m_dd, m_allrdy, p_stall;
    int            m_wi, m_rd, m_hs, m_len, m_dcyc, m_beats;
    logic [DW-1:0] m_exp [DEPTH];
    logic [DW-1:0] m_last, p_data;
    int            n_cd = 0, n_dd = 0;
    time           t_cd = 0, t_dd = 0;

    always @(negedge clk) begin
        int  mode0;
        bit  hs, nxt_cd, nxt_dd, st_d, st_c;
        if (rst) begin
            m_mode = 0; m_prev_c = 0; m_prev_d = 0; m_cp = 0; m_dp = 0; m_cd = 0; m_dd = 0;
            m_wi = 0; m_rd = 0; m_hs = 0; m_len = 0; m_dcyc = 0; p_stall = 0;
        end else begin
            chk("hold_compute", hold_compute, (m_mode != 0) || m_cp || m_dp);
            chk("clear_done", clear_done, m_cd);
            chk("drain_done", drain_done, m_dd);
            if (clear_done) begin n_cd++; t_cd = $time; end
            if (drain_done) begin n_dd++; t_dd = $time; end
            if (p_stall) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data", m_axis_tdata, p_data);
            end
            mode0 = m_mode;
            nxt_cd = 0; nxt_dd = 0;
            hs = m_axis_tvalid && m_axis_tready;
            if (m_mode == 0) begin
                chk("idle_en", bram_en, 0);
                chk("idle_valid", m_axis_tvalid, 0);
            end else if (m_mode == 1) begin
                chk("clr_en_we", {bram_en, bram_we}, 2'b11);
                chk("clr_addr", bram_addr, m_wi);
                chk("clr_wdata", bram_wdata, 0);
                chk("clr_valid", m_axis_tvalid, 0);
                if (m_wi == DEPTH - 1) begin m_mode = 0; nxt_cd = 1; end
                else m_wi++;
            end else begin
                if (bram_en) begin
                    chk("rd_we", bram_we, 0);
                    chk("rd_addr", bram_addr, m_rd);
                    chk("rd_in_range", m_rd < m_len, 1);
                    m_rd++;
                end
                if (!m_axis_tready) m_allrdy = 0;
                if (m_dcyc < 2) chk("valid_too_early", m_axis_tvalid, 0);
                else if (m_allrdy && m_hs < m_len) chk("full_rate_valid", m_axis_tvalid, 1);
                if (m_axis_tvalid) chk("tlast", m_axis_tlast, m_hs == m_len - 1);
                if (hs) begin
                    chk("beat_in_range", m_hs < m_len, 1);
                    if (m_hs < m_len) chk("tdata", m_axis_tdata, m_exp[m_hs]);
                    m_beats++;
                    if (m_hs == m_len - 1) begin m_last = m_axis_tdata; m_mode = 0; nxt_dd = 1; end
                    m_hs++;
                end
                m_dcyc++;
            end
            st_d = (mode0 == 0) && m_dp;
            st_c = (mode0 == 0) && !m_dp && m_cp;
            if (st_d) begin
                m_mode = 2;
                m_len = (current_layer_id == 2'd1) ? LEN1 : LEN0;
                for (int i = 0; i < DEPTH; i++) m_exp[i] = mem[i];
                m_rd = 0; m_hs = 0; m_dcyc = 0; m_allrdy = 1; m_beats = 0;
            end else if (st_c) begin
                m_mode = 1;
                m_wi = 0;
            end
            m_dp = (all_batches_complete && !m_prev_d) || (m_dp && !st_d);
            m_cp = (clear_output_bram && !m_prev_c) || (m_cp && !st_c);
            m_prev_d = all_batches_complete;
            m_prev_c = clear_output_bram;
            m_cd = nxt_cd;
            m_dd = nxt_dd;
            p_stall = m_axis_tvalid && !m_axis_tready;
            p_data = m_axis_tdata;
        end
    end

    int ready_mode = 0;
    int tog = 0;
    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       begin tog = tog ^ 1; m_axis_tready = tog[0]; end
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    int wait_arg = 0;
    function automatic bit cond(input int sel);
        case (sel)
            0:       return drain_done;
            1:       return clear_done;
            2:       return m_axis_tvalid;
            default: return m_hs >= wait_arg;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string nm, output int n);
        n = 0;
        do begin tick(); n++; end while (!cond(sel) && n < budget);
        chk({nm, "_reached"}, cond(sel), 1);
    endtask

    task automatic load(input logic [DW-1:0] key);
        load_key = key;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, nz;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bram_en, bram_we, bram_addr, m_axis_tvalid, m_axis_tlast, hold_compute, clear_done, drain_done}, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        rst = 1'b0;
        tick();
        load(16'h0000);

        // layer 1, full ready: 512 beats 0..511
        ready_mode = 0;
        current_layer_id = 2'd1;
        all_batches_complete = 1'b1;
        wait_for(2, 20, "t2_first_valid", n);
        chk("t2_first_valid_cycle", n, 4);
        wait_for(0, 2000, "t2_done", n2);
        chk("t2_done_cycle", n + n2, 516);
        chk("t2_beats", m_beats, 512);
        chk("t2_last_word", m_last, 16'd511);
        tick();
        chk("t2_done_one_cycle", drain_done, 0);
        all_batches_complete = 1'b0;
        tick();

        // layer 0, toggling ready then random ready
        ready_mode = 1;
        current_layer_id = 2'd0;
        all_batches_complete = 1'b1;
        wait_for(0, 6000, "t3a_done", n);
        chk("t3a_beats", m_beats, 1024);
        chk("t3a_last_word", m_last, 16'd1023);
        all_batches_complete = 1'b0;
        tick();
        ready_mode = 2;
        load(16'h5A5A);
        current_layer_id = 2'd3;
        all_batches_complete = 1'b1;
        wait_for(0, 8000, "t3b_done", n);
        chk("t3b_beats", m_beats, 1024);
        chk("t3b_last_word", m_last, 16'h59A5);
        all_batches_complete = 1'b0;
        ready_mode = 0;
        tick();

        // single clear pulse
        clear_output_bram = 1'b1;
        tick();
        clear_output_bram = 1'b0;
        chk("t1_hold_on_request", hold_compute, 1);
        wait_for(1, 2000, "t1_done", n);
        chk("t1_done_cycle", n + 1, 1026);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 0) nz++;
        chk("t1_mem_zeroed", nz, 0);
        tick();

        // simultaneous requests: drain first, then clear
        load(16'h1234);
        n_cd = 0; n_dd = 0;
        current_layer_id = 2'd1;
        clear_output_bram = 1'b1;
        all_batches_complete = 1'b1;
        tick();
        clear_output_bram = 1'b0;
        wait_for(1, 3000, "t4_clear_done", n);
        tick(); tick();
        chk("t4_drain_pulses", n_dd, 1);
        chk("t4_clear_pulses", n_cd, 1);
        chk("t4_drain_before_clear", t_dd < t_cd, 1);
        chk("t4_last_word", m_last, 16'h13CB);
        all_batches_complete = 1'b0;
        tick();

        // clear edge arriving mid-drain at word 100
        load(16'h00F0);
        all_batches_complete = 1'b1;
        wait_arg = 100;
        wait_for(3, 1000, "t5_word100", n);
        clear_output_bram = 1'b1;
        tick();
        clear_output_bram = 1'b0;
        wait_for(0, 2000, "t5_drain_done", n);
        chk("t5_last_word", m_last, 16'h010F);
        tick();
        chk("t5_clear_start", {bram_en, bram_we, bram_addr}, {2'b11, 10'd0});
        wait_for(1, 2000, "t5_clear_done", n);
        all_batches_complete = 1'b0;
        tick();

        // reset mid-drain at word 300, then restart
        load(16'h0000);
        current_layer_id = 2'd0;
        all_batches_complete = 1'b1;
        wait_arg = 300;
        wait_for(3, 1000, "t6_word300", n);
        rst = 1'b1;
        #1;
        chk("t6_reset_outputs", {bram_en, bram_we, bram_addr, m_axis_tvalid, m_axis_tlast, hold_compute, clear_done, drain_done}, 0);
        chk("t6_reset_tdata", m_axis_tdata, 0);
        all_batches_complete = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t6_idle_after_reset", hold_compute, 0);
        all_batches_complete = 1'b1;
        wait_for(0, 2000, "t6_done", n);
        chk("t6_beats", m_beats, 1024);
        chk("t6_last_word", m_last, 16'd1023);
        all_batches_complete = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
